ls395a_sequencer: RTL

//  Upstream controller for a chain of LS395A 4-bit shift registers (cascaded via carry).

---
 rtl/ls395a_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ls395a_sequencer.sv
// Upstream load/shift sequencer for a cascaded LS395A chain; recaptures the carry stream.
// Optional loopback compare enabled by defining LS395A_LOOPCHK_EN.
module ls395a_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iWord,
  input  logic             iSerIn,
  output logic [WIDTH-1:0] oPData,
  output logic             oLDSH,
  output logic             oSER,
  output logic             oRegClr,
  input  logic             iCarry,
  output logic [WIDTH-1:0] oWord,
  output logic             oWordValid,
  output logic             oMismatch
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Handshake: a word is accepted on a posedge where iValid && oReady; no buffering.
  state_t           state, next_state;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] cap, cap_next;
  logic [WIDTH-1:0] pdata_next, word_next;
  logic             ldsh_next, ser_next, wvalid_next;
`ifdef LS395A_LOOPCHK_EN
  logic             mism_next;
  logic             mism_q;
`endif

  assign oReady  = (state == IDLE);
  assign oRegClr = iClr;

  always_ff @(posedge iClk) begin
    if (iClr) begin
      state      <= IDLE;
      cnt        <= '0;
      cap        <= '0;
      oPData     <= '0;
      oLDSH      <= 1'b0;
      oSER       <= 1'b0;
      oWord      <= '0;
      oWordValid <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      cap        <= cap_next;
      oPData     <= pdata_next;
      oLDSH      <= ldsh_next;
      oSER       <= ser_next;
      oWord      <= word_next;
      oWordValid <= wvalid_next;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iValid) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // oSER holds the fill bit after SHIFT so the free-running chain keeps repeating it.
  always_comb begin
    pdata_next  = oPData;
    ldsh_next   = 1'b0;
    ser_next    = oSER;
    word_next   = oWord;
    wvalid_next = 1'b0;
    cnt_next    = cnt;
    cap_next    = cap;
`ifdef LS395A_LOOPCHK_EN
    mism_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (iValid) begin
          pdata_next = iWord;
          ldsh_next  = 1'b1;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        cap_next = {cap[WIDTH-2:0], iCarry};
        cnt_next = '0;
        ser_next = iSerIn;
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cap_next = {cap[WIDTH-2:0], iCarry};
          cnt_next = cnt + CW'(1);
          ser_next = iSerIn;
        end else begin
          word_next   = cap;
          wvalid_next = 1'b1;
`ifdef LS395A_LOOPCHK_EN
          mism_next   = (cap != oPData);
`endif
        end
      end
      default: ;
    endcase
  end

`ifdef LS395A_LOOPCHK_EN
  always_ff @(posedge iClk) begin
    if (iClr) mism_q <= 1'b0;
    else      mism_q <= mism_next;
  end
  assign oMismatch = mism_q;
`else
  assign oMismatch = 1'b0;
`endif

endmodule
